// File: rtl/mux_select_sequencer_if.sv
// Switch/button inputs and mux select/LED outputs of the LED mux control front-end.
interface mux_select_sequencer_if;
  logic [3:0] sw;
  logic [1:0] btn;
  logic [1:0] sel;
  logic       led;
  logic       scan_mode;

  modport master (output sw, output btn, input sel, input led, input scan_mode);
  modport slave  (input sw, input btn, output sel, output led, output scan_mode);
endinterface

// File: rtl/mux_select_sequencer.sv
// Button synchronise/debounce/edge front-end driving a 4:1 LED mux select,
// stepped manually by btn[0] or auto-rotated in SCAN mode (btn[1] toggles).
module mux_select_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_PERIOD     = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  mux_select_sequencer_if.slave bus
);

  localparam int DB_W = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SC_W = ($clog2(SCAN_PERIOD) < 1) ? 1 : $clog2(SCAN_PERIOD);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_PERIOD - 1);

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} mode_t;

  logic [1:0]      sync_p0, sync_p1;
  logic [1:0]      db, db_d, pulse, armed;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      fill;
  logic            fill_done;

  mode_t           state_q, state_d;
  logic [SC_W-1:0] scan_cnt, scan_cnt_d;
  logic            step;
  logic [1:0]      sel;
  logic            led;

  // The synchroniser still carries reset zeros for two cycles after reset; a
  // button only arms once a genuine released level has come through, so a
  // button held across reset never produces a pulse.
  assign fill_done = (fill == 2'd2);

  // Stage p0/p1: two-flop synchroniser, then debouncer and registered edge pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      db      <= '0;
      db_d    <= '0;
      pulse   <= '0;
      armed   <= '0;
      fill    <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= bus.btn;
      sync_p1 <= sync_p0;
      db_d    <= db;
      if (!fill_done) fill <= fill + 2'd1;
      for (int i = 0; i < 2; i++) begin
        if (fill_done && !sync_p1[i]) armed[i] <= 1'b1;
        if (sync_p1[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
        pulse[i] <= armed[i] & db[i] & ~db_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= MANUAL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (pulse[1]) state_d = (state_q == MANUAL) ? SCAN : MANUAL;
  end

  // A mode toggle always suppresses the step of the same cycle, manual or scan.
  always_comb begin
    step       = 1'b0;
    scan_cnt_d = scan_cnt;
    case (state_q)
      MANUAL: begin
        scan_cnt_d = '0;
        step       = pulse[0] & ~pulse[1];
      end
      SCAN: begin
        if (scan_cnt == SC_LAST) begin
          scan_cnt_d = '0;
          step       = ~pulse[1];
        end else begin
          scan_cnt_d = scan_cnt + SC_W'(1);
        end
      end
      default: ;
    endcase
    if (pulse[1]) scan_cnt_d = '0;
  end

  // Stage p2: select, scan counter and registered LED
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel      <= '0;
      scan_cnt <= '0;
      led      <= 1'b0;
    end else begin
      if (step) sel <= sel + 2'd1;
      scan_cnt <= scan_cnt_d;
      led      <= bus.sw[sel];
    end
  end

  assign bus.sel       = sel;
  assign bus.led       = led;
  assign bus.scan_mode = (state_q == SCAN);

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench for mux_select_sequencer: window-based behavioural model plus
// hand-computed checkpoints for reset, debounce, manual wrap, scan, collisions.
module tb_mux_select_sequencer;
  localparam int DB = 4;
  localparam int SP = 8;

  logic clk = 1'b0;
  logic rst_n;
  mux_select_sequencer_if bus();

  mux_select_sequencer #(.DEBOUNCE_CYCLES(DB), .SCAN_PERIOD(SP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: a button's debounced level flips once the last DB synchronised
  // samples all disagree with it; a pulse follows one cycle after a rise.
  logic [1:0] m_sel;
  logic       m_mode, m_led, new_led;
  int         m_age, since_rst;
  bit [1:0]   r1, r2, s2, mdb, mrose, mpulse, marmed, pnext;
  bit         hist [2][DB];
  bit         all_diff;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_sel = '0; m_mode = 1'b0; m_led = 1'b0; m_age = 0; since_rst = 0;
      r1 = '0; r2 = '0; mdb = '0; mrose = '0; mpulse = '0; marmed = '0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < DB; i++) hist[b][i] = 1'b0;
    end else begin
      new_led = bus.sw[m_sel];
      if (mpulse[1]) begin
        m_mode = ~m_mode;
        m_age  = 0;
      end else if (m_mode) begin
        m_age++;
        if (m_age % SP == 0) m_sel = m_sel + 2'd1;
      end else if (mpulse[0]) begin
        m_sel = m_sel + 2'd1;
      end
      s2 = r2;
      for (int b = 0; b < 2; b++) begin
        pnext[b] = marmed[b] & mrose[b];
        if (since_rst >= 2 && !s2[b]) marmed[b] = 1'b1;
        for (int i = DB - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = s2[b];
        all_diff = 1'b1;
        for (int i = 0; i < DB; i++) if (hist[b][i] == mdb[b]) all_diff = 1'b0;
        mrose[b] = 1'b0;
        if (all_diff) begin
          mdb[b]   = s2[b];
          mrose[b] = s2[b];
        end
      end
      mpulse = pnext;
      r2 = r1;
      r1 = bus.btn;
      since_rst++;
      m_led = new_led;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_sel", {2'b0, bus.sel}, {2'b0, m_sel});
      check("model_scan_mode", {3'b0, bus.scan_mode}, {3'b0, m_mode});
      check("model_led", {3'b0, bus.led}, {3'b0, m_led});
    end
  end

  logic [1:0] sel_tab [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic       led_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0; bus.btn = 2'b11; bus.sw = 4'hF;
    cyc(1); chk_en = 1'b1; cyc(2);
    check("t1_rst_sel", {2'b0, bus.sel}, 4'd0);
    check("t1_rst_mode", {3'b0, bus.scan_mode}, 4'd0);
    check("t1_rst_led", {3'b0, bus.led}, 4'd0);
    rst_n = 1'b1; cyc(20);
    check("t1_held_sel", {2'b0, bus.sel}, 4'd0);
    check("t1_held_mode", {3'b0, bus.scan_mode}, 4'd0);
    bus.btn = 2'b00; cyc(12);
    check("t1_release_sel", {2'b0, bus.sel}, 4'd0);

    // debounce: short glitch rejected, long press steps 8 cycles later
    bus.sw = 4'b1010; bus.btn = 2'b01; cyc(3); bus.btn = 2'b00; cyc(12);
    check("t2_glitch_sel", {2'b0, bus.sel}, 4'd0);
    bus.btn = 2'b01; cyc(7);
    check("t2_sel_at7", {2'b0, bus.sel}, 4'd0);
    cyc(1);
    check("t2_sel_at8", {2'b0, bus.sel}, 4'd1);
    cyc(2); bus.btn = 2'b00; cyc(12);

    // manual wrap from a fresh reset
    rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(4);
    for (int i = 0; i < 4; i++) begin
      bus.btn = 2'b01; cyc(8);
      check("t3_sel", {2'b0, bus.sel}, {2'b0, sel_tab[i]});
      cyc(1);
      check("t3_led", {3'b0, bus.led}, {3'b0, led_tab[i]});
      cyc(1); bus.btn = 2'b00; cyc(12);
    end

    // scan: enter, auto-step, ignore btn[0], leave on a due step
    bus.btn = 2'b10; cyc(8);
    check("t4_enter_mode", {3'b0, bus.scan_mode}, 4'd1);
    check("t4_enter_sel", {2'b0, bus.sel}, 4'd0);
    for (int k = 1; k <= 68; k++) begin
      cyc(1);
      if (k % 8 == 0 && k <= 40) check("t4_scan_sel", {2'b0, bus.sel}, 4'((k / 8) % 4));
      if (k == 7) check("t4_pre_step_sel", {2'b0, bus.sel}, 4'd0);
      if (k == 47) check("t4_still_scan", {3'b0, bus.scan_mode}, 4'd1);
      if (k == 48) begin
        check("t4_exit_mode", {3'b0, bus.scan_mode}, 4'd0);
        check("t4_exit_sel", {2'b0, bus.sel}, 4'd1);
      end
      if (k == 68) check("t4_frozen_sel", {2'b0, bus.sel}, 4'd1);
      if (k == 2)  bus.btn = 2'b00;
      if (k == 4)  bus.btn = 2'b01;
      if (k == 14) bus.btn = 2'b00;
      if (k == 40) bus.btn = 2'b10;
      if (k == 50) bus.btn = 2'b00;
    end

    // collision in both directions
    bus.btn = 2'b11; cyc(8);
    check("t5_coll_mode", {3'b0, bus.scan_mode}, 4'd1);
    check("t5_coll_sel", {2'b0, bus.sel}, 4'd1);
    cyc(2); bus.btn = 2'b00; cyc(10);
    bus.btn = 2'b11; cyc(8);
    check("t5_coll2_mode", {3'b0, bus.scan_mode}, 4'd0);
    check("t5_coll2_sel", {2'b0, bus.sel}, 4'd3);
    cyc(2); bus.btn = 2'b00; cyc(12);

    // reset mid-scan at sel=2
    bus.btn = 2'b01; cyc(8);
    check("t6_wrap_sel", {2'b0, bus.sel}, 4'd0);
    cyc(2); bus.btn = 2'b00; cyc(12);
    bus.btn = 2'b10; cyc(8);
    check("t6_scan_mode", {3'b0, bus.scan_mode}, 4'd1);
    cyc(2); bus.btn = 2'b00; cyc(14);
    check("t6_sel_before", {2'b0, bus.sel}, 4'd2);
    cyc(2); rst_n = 1'b0; cyc(1);
    check("t6_rst_sel", {2'b0, bus.sel}, 4'd0);
    check("t6_rst_mode", {3'b0, bus.scan_mode}, 4'd0);
    check("t6_rst_led", {3'b0, bus.led}, 4'd0);
    rst_n = 1'b1; cyc(20);
    check("t6_idle_sel", {2'b0, bus.sel}, 4'd0);
    check("t6_idle_mode", {3'b0, bus.scan_mode}, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
